// File: rtl/dnn_pkg.sv
// Shared widths, saturation helper and result entry type for the DNN readout.
// Used by dnn_result_fifo and dnn_result_reader.
package dnn_pkg;

  localparam int DNN_IN_SIZE  = 21;
  localparam int DNN_OUT_SIZE = 16;

  typedef struct packed {
    logic signed [DNN_OUT_SIZE-1:0] score0;
    logic signed [DNN_OUT_SIZE-1:0] score1;
    logic                           cls;
  } res_t;

  // Clamp a 32-bit signed value to the signed range of a w-bit word (w < 32).
  function automatic logic signed [31:0] sat(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/dnn_result_fifo.sv
// First-word-fall-through FIFO of result entries; head visible on dout.
// Ports: clk, rst_n, clr, push, pop, din, dout, full, empty, level.
module dnn_result_fifo
  import dnn_pkg::*;
#(
  parameter type T     = res_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  T              mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [LW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr] <= din;
  end

endmodule

// File: rtl/dnn_result_reader.sv
// Captures paired MAC results, scales/saturates/classifies, queues them out.
// Optional DNN_RESULT_RELU_EN clamps negative inputs to 0 before scaling.
module dnn_result_reader
  import dnn_pkg::*;
#(
  parameter int IN_SIZE    = DNN_IN_SIZE,
  parameter int OUT_SIZE   = DNN_OUT_SIZE,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic signed [IN_SIZE-1:0]  mac_in0,
  input  logic signed [IN_SIZE-1:0]  mac_in1,
  input  logic                       mac_ready0,
  input  logic                       mac_ready1,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [OUT_SIZE-1:0] res_score0,
  output logic signed [OUT_SIZE-1:0] res_score1,
  output logic                       res_class,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [LW-1:0]              fifo_level,
  output logic                       overflow,
  output logic                       strobe_err
);

  typedef struct packed {
    logic signed [OUT_SIZE-1:0] score0;
    logic signed [OUT_SIZE-1:0] score1;
    logic                       cls;
  } entry_t;

  function automatic logic signed [OUT_SIZE-1:0] scale(
    input logic signed [IN_SIZE-1:0] v
  );
    logic signed [31:0] ext;
    ext = 32'(v);
    return OUT_SIZE'(sat(ext >>> SHIFT, OUT_SIZE));
  endfunction

  logic signed [IN_SIZE-1:0] v0;
  logic signed [IN_SIZE-1:0] v1;
  entry_t                    din;
  entry_t                    dout;
  logic                      cap;
  logic                      mism;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      accept;
  logic                      drop;

`ifdef DNN_RESULT_RELU_EN
  assign v0 = mac_in0[IN_SIZE-1] ? '0 : mac_in0;
  assign v1 = mac_in1[IN_SIZE-1] ? '0 : mac_in1;
`else
  assign v0 = mac_in0;
  assign v1 = mac_in1;
`endif

  assign cap    = mac_ready0 & mac_ready1;
  assign mism   = mac_ready0 ^ mac_ready1;
  assign pop    = res_valid & res_ready;
  assign accept = cap && (!full || pop);
  assign drop   = cap && full && !pop;

  // class uses the raw inputs so ReLU clamping cannot hide a winner
  assign din.score0 = scale(v0);
  assign din.score1 = scale(v1);
  assign din.cls    = (mac_in1 > mac_in0);

  dnn_result_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (cap),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign res_valid  = !empty;
  assign res_score0 = dout.score0;
  assign res_score1 = dout.score1;
  assign res_class  = dout.cls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      overflow   <= 1'b0;
      strobe_err <= 1'b0;
    end else if (clr) begin
      frame_cnt  <= '0;
      overflow   <= 1'b0;
      strobe_err <= 1'b0;
    end else begin
      if (accept) frame_cnt  <= frame_cnt + 1'b1;
      if (drop)   overflow   <= 1'b1;
      if (mism)   strobe_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dnn_result_reader.sv
// Scoreboard bench for dnn_result_reader: stimulus queues expected entries,
// a negedge monitor pops and compares each accepted head entry.
module tb_dnn_result_reader;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic signed [20:0] mac_in0 = '0;
  logic signed [20:0] mac_in1 = '0;
  logic               mac_ready0 = 1'b0;
  logic               mac_ready1 = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic signed [15:0] res_score0;
  logic signed [15:0] res_score1;
  logic               res_class;
  logic [7:0]         frame_cnt;
  logic [2:0]         fifo_level;
  logic               overflow;
  logic               strobe_err;

  typedef struct packed {
    logic signed [15:0] s0;
    logic signed [15:0] s1;
    logic               c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dnn_result_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .mac_in0    (mac_in0),
    .mac_in1    (mac_in1),
    .mac_ready0 (mac_ready0),
    .mac_ready1 (mac_ready1),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_score0 (res_score0),
    .res_score1 (res_score1),
    .res_class  (res_class),
    .frame_cnt  (frame_cnt),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .strobe_err (strobe_err)
  );

  function automatic int rl(input int x);
`ifdef DNN_RESULT_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string n, input logic signed [31:0] a,
                     input logic signed [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_valid"}, res_valid, 0);
    chk({t, "_s0"}, res_score0, 0);
    chk({t, "_s1"}, res_score1, 0);
    chk({t, "_class"}, res_class, 0);
    chk({t, "_cnt"}, frame_cnt, 0);
    chk({t, "_level"}, fifo_level, 0);
    chk({t, "_ovf"}, overflow, 0);
    chk({t, "_serr"}, strobe_err, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int s0, input int s1, input logic c);
    exp_t e;
    e.s0 = 16'(s0);
    e.s1 = 16'(s1);
    e.c  = c;
    q.push_back(e);
  endtask

  task automatic frame(input logic signed [20:0] a,
                       input logic signed [20:0] b);
    mac_in0    = a;
    mac_in1    = b;
    mac_ready0 = 1'b1;
    mac_ready1 = 1'b1;
    step();
    mac_ready0 = 1'b0;
    mac_ready1 = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    #1;
    res_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop_extra: got s0=%0d s1=%0d c=%0d want none",
                 res_score0, res_score1, res_class);
      end else begin
        e = q.pop_front();
        if (res_score0 !== e.s0 || res_score1 !== e.s1 ||
            res_class !== e.c) begin
          bad++;
          $display("FAIL pop_data: got %0d/%0d/%0d want %0d/%0d/%0d",
                   res_score0, res_score1, res_class, e.s0, e.s1, e.c);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    step();

    res_ready = 1'b1;
    expect_res(6, rl(-4), 1'b0);
    frame(21'sd100, -21'sd50);
    @(negedge clk);
    chk("basic_cnt", frame_cnt, 1);
    chk("basic_valid", res_valid, 1);
    step();

    expect_res(32767, rl(-32768), 1'b0);
    frame(21'sd1048575, -21'sd1048576);
    expect_res(1, 1, 1'b0);
    frame(21'sd30, 21'sd30);
    expect_res(rl(-1), 0, 1'b1);
    frame(-21'sd5, 21'sd7);
    drain();
    @(negedge clk);
    chk("seq_cnt", frame_cnt, 4);
    chk("seq_valid", res_valid, 0);
    step();

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", frame_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_res(k, rl(-k), 1'b0);
      frame(21'(16 * k), 21'(-16 * k));
    end
    @(negedge clk);
    chk("bp_level", fifo_level, 4);
    chk("bp_ovf", overflow, 1);
    chk("bp_cnt", frame_cnt, 4);
    chk("bp_head", res_score0, 1);
    step();
    chk("bp_hold", res_score0, 1);
    drain();
    @(negedge clk);
    chk("bp_empty", res_valid, 0);
    chk("bp_level0", fifo_level, 0);
    step();

    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      expect_res(k, rl(-k), 1'b0);
      frame(21'(16 * k), 21'(-16 * k));
    end
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_ovf", overflow, 0);
    step();
    res_ready = 1'b1;
    expect_res(14, rl(-14), 1'b0);
    frame(21'sd224, -21'sd224);
    res_ready = 1'b0;
    @(negedge clk);
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_cnt", frame_cnt, 5);
    step();
    drain();

    mac_ready0 = 1'b1;
    step();
    mac_ready0 = 1'b0;
    chk("se_flag", strobe_err, 1);
    chk("se_level", fifo_level, 0);
    chk("se_cnt", frame_cnt, 5);
    clr = 1'b1;
    mac_ready0 = 1'b1;
    mac_ready1 = 1'b1;
    step();
    clr = 1'b0;
    mac_ready0 = 1'b0;
    mac_ready1 = 1'b0;
    chk("clr_serr", strobe_err, 0);
    chk("clr_cnt2", frame_cnt, 0);
    chk("clr_level", fifo_level, 0);

    expect_res(3, 5, 1'b1);
    frame(21'sd50, 21'sd80);
    expect_res(2, 1, 1'b0);
    frame(21'sd40, 21'sd20);
    expect_res(0, 0, 1'b0);
    frame(21'sd0, 21'sd0);
    chk("ar_level", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    q.delete();
    step();
    rst_n = 1'b1;
    step();
    res_ready = 1'b1;
    expect_res(3, 5, 1'b1);
    frame(21'sd50, 21'sd80);
    @(negedge clk);
    chk("ar_cnt", frame_cnt, 1);
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
